// File: rtl/booth_pkg.sv
// Shared constants and types for the Booth multiply-accumulate path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: product width, default accumulator/count widths, FSM state
// enum and the signed saturation bounds of a PROD_W result.
package booth_pkg;

  localparam int PROD_W    = 64;
  localparam int ACC_W_DEF = 72;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [PROD_W-1:0] SAT_MAX = {1'b0, {(PROD_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN = {1'b1, {(PROD_W-1){1'b0}}};

endpackage

// File: rtl/booth_sat.sv
// Clips a wide signed accumulator to a PROD_W signed result.
// Latency: purely combinational.
// Backpressure: none; no handshake.
// Ports: acc_in (ACC_W signed in), sum (PROD_W signed out), sat (1 = clipped).
module booth_sat
  import booth_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [PROD_W-1:0] sum,
  output logic                     sat
);

  // The value fits in PROD_W exactly when every bit from the PROD_W sign
  // position upward is a copy of the same bit.
  logic [ACC_W-PROD_W:0] top_bits;
  assign top_bits = acc_in[ACC_W-1:PROD_W-1];

  always_comb begin
    sat = !((&top_bits) || !(|top_bits));
    if (!sat) begin
      sum = acc_in[PROD_W-1:0];
    end else if (acc_in[ACC_W-1]) begin
      sum = SAT_MIN;
    end else begin
      sum = SAT_MAX;
    end
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums a programmed count of signed products and returns a saturated result.
// Latency: result valid the cycle after the last product is accepted (len=0: cycle after start).
// Backpressure: in_ready only in ACC; result held stable in DONE until out_ready.
// Ports: clk/rst (async active-high); start+len begin a run from IDLE;
//   in_valid/in_ready/product take products; out_valid/out_ready/sum_out/sat
//   return the result; busy is high outside IDLE.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W = booth_pkg::PROD_W,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [PROD_W-1:0] sum_out,
  output logic                     sat,
  output logic                     busy
);

  state_t state, state_nxt;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic [LEN_W-1:0]         remaining;
  logic                     take;
  logic                     last_take;
  logic                     run_load;
  logic signed [PROD_W-1:0] sat_sum;
  logic                     sat_flag;

  assign take      = in_valid && in_ready;
  assign last_take = take && (remaining == LEN_W'(1));
  assign run_load  = (state == IDLE) && start;
  assign acc_nxt   = acc + {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

  // Saturate the post-add value so the output register captures the final
  // sum in the same edge that accepts the last product.
  booth_sat #(
    .ACC_W (ACC_W)
  ) u_sat (
    .acc_in (acc_nxt),
    .sum    (sat_sum),
    .sat    (sat_flag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs decode registered state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (last_take) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      remaining <= '0;
      sum_out   <= '0;
      sat       <= 1'b0;
    end else if (run_load) begin
      acc       <= '0;
      remaining <= len;
      // An empty run reports zero without passing through ACC.
      if (len == '0) begin
        sum_out <= '0;
        sat     <= 1'b0;
      end
    end else if (take) begin
      acc       <= acc_nxt;
      remaining <= remaining - LEN_W'(1);
      if (last_take) begin
        sum_out <= sat_sum;
        sat     <= sat_flag;
      end
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Scoreboard bench for booth_product_accumulator.
// Stimulus pushes hand-computed expected results; a negedge monitor pops on
// each output handshake and also checks latency and products consumed.
module tb_booth_product_accumulator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [7:0]         len = 8'd0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [63:0] product = 64'sd0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [63:0] sum_out;
  logic               sat;
  logic               busy;

  booth_product_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .sat       (sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [63:0] sum;
    logic               sat;
    int                 n;
  } exp_t;

  exp_t               exp_q[$];
  logic signed [63:0] pq[$];
  int                 vectors = 0;
  int                 miscompares = 0;
  int                 cyc = 0;

  localparam logic signed [63:0] P62  = 64'sh4000_0000_0000_0000;
  localparam logic signed [63:0] N62  = 64'shC000_0000_0000_0000;
  localparam logic signed [63:0] MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [63:0] MINV = 64'sh8000_0000_0000_0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor / scoreboard
  int run_cnt  = 0;
  int last_evt = 0;
  bit prev_ov  = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run_cnt = 0;
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        run_cnt++;
        last_evt = cyc;
      end
      if (start && !busy) last_evt = cyc;
      if (out_valid && !prev_ov) check("latency", 64'(cyc - last_evt), 64'(1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got sum %h with empty scoreboard", sum_out);
        end else begin
          e = exp_q.pop_front();
          check("sum_out", sum_out, e.sum);
          check("sat", {63'b0, sat}, {63'b0, e.sat});
          check("products_taken", 64'(run_cnt), 64'(e.n));
        end
        run_cnt = 0;
      end
      prev_ov = out_valid;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 600) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy !== 1'b0) check("wait_idle_timeout", {63'b0, busy}, 64'(0));
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    len   = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len   = 8'd0;  // must not disturb the run in progress
  endtask

  task automatic send(input logic signed [63:0] p, input int stall);
    bit ok;
    int t = 0;
    in_valid = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    product  = p;
    do begin
      ok = in_ready;
      @(posedge clk); #1;
      t++;
    end while (!ok && t < 200);
    if (!ok) check("send_timeout", 64'(t), 64'(0));
    in_valid = 1'b0;
  endtask

  task automatic run(input int n, input int stall, input logic signed [63:0] esum, input logic esat);
    exp_q.push_back('{sum: esum, sat: esat, n: n});
    wait_idle();
    if (n == 0) begin
      in_valid = 1'b1;
      product  = 64'sd777;
    end
    do_start(n);
    if (n == 0) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    foreach (pq[i]) send(pq[i], stall);
  endtask

  task automatic load_basic();
    pq = '{64'sd83810205, -64'sd50000, -64'sd512000, 64'sd300000};
  endtask

  initial begin
    int t;
    // Reset state while rst is held
    #2;
    check("rst_in_ready", {63'b0, in_ready}, 64'(0));
    check("rst_out_valid", {63'b0, out_valid}, 64'(0));
    check("rst_busy", {63'b0, busy}, 64'(0));
    check("rst_sat", {63'b0, sat}, 64'(0));
    check("rst_sum_out", sum_out, 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    load_basic();
    run(4, 0, 64'sd83548205, 1'b0);
    run(4, 3, 64'sd83548205, 1'b0);

    pq = '{P62, P62};
    run(2, 0, MAXV, 1'b1);
    pq = '{N62, N62, N62};
    run(3, 0, MINV, 1'b1);
    pq = '{P62, P62 - 64'sd1};
    run(2, 1, MAXV, 1'b0);
    pq = '{N62, N62};
    run(2, 0, MINV, 1'b0);

    pq = {};
    run(0, 0, 64'sd0, 1'b0);

    // Backpressure in DONE with start and a product offered
    wait_idle();
    out_ready = 1'b0;
    load_basic();
    run(4, 0, 64'sd83548205, 1'b0);
    t = 0;
    while (out_valid !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      start    = 1'b1;
      in_valid = 1'b1;
      product  = 64'sd123;
      check("bp_out_valid", {63'b0, out_valid}, 64'(1));
      check("bp_in_ready", {63'b0, in_ready}, 64'(0));
      check("bp_sum_stable", sum_out, 64'sd83548205);
      @(posedge clk); #1;
      start = (i % 2 == 0) ? 1'b0 : 1'b1;
    end
    start     = 1'b1;  // coincides with the DONE->IDLE handshake
    out_ready = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    check("bp_release_busy", {63'b0, busy}, 64'(0));
    @(posedge clk); #1;
    check("bp_start_ignored", {63'b0, busy}, 64'(0));

    // Mid-run asynchronous reset discards the partial run
    wait_idle();
    do_start(4);
    send(64'sd1000, 0);
    send(64'sd2000, 0);
    in_valid = 1'b1;
    product  = 64'sd5;
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", {63'b0, in_ready}, 64'(0));
    check("midrst_out_valid", {63'b0, out_valid}, 64'(0));
    check("midrst_busy", {63'b0, busy}, 64'(0));
    check("midrst_sat", {63'b0, sat}, 64'(0));
    check("midrst_sum_out", sum_out, 64'(0));
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    load_basic();
    run(4, 0, 64'sd83548205, 1'b0);

    // Longest run: 255 * (2^63-1) fits ACC_W and clips high
    pq = {};
    for (int i = 0; i < 255; i++) pq.push_back(MAXV);
    run(255, 0, MAXV, 1'b1);

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
